// File: rtl/mem_ctrl.sv
// Purpose: single-port 2^ADDR_W x 32 RAM behind a MAR/MDR-style four-state handshake (IDLE/WAIT/ACCESS/DONE); MEM_RANGE_CHECK_EN enables out-of-range detection.
// Latency: Done pulses in the (WAIT_STATES+2)th cycle after the request-sampling edge; back-to-back period is WAIT_STATES+3 cycles.
// Backpressure: none queued; Read/Write are sampled only in IDLE and ignored while Busy is high.
module mem_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] MARaddr,
    input  logic [31:0] MDRdata,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] Mdatain,
    output logic        MDMuxread,
    output logic        Done,
    output logic        Busy,
    output logic        Err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] WAIT_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          wait_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic                op_rd;
    logic                oor_q;
    logic                oor_req;
    logic                req;
    logic [31:0]         mem [2**ADDR_W];

    assign req = Read | Write;

`ifdef MEM_RANGE_CHECK_EN
    assign oor_req = |MARaddr[31:ADDR_W];
`else
    // Upper address bits are deliberately ignored; the address wraps.
    logic unused_upper;
    assign unused_upper = ^MARaddr[31:ADDR_W];
    assign oor_req      = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wait_cnt <= 2'd0;
        end else if (state == S_WAIT && state_nxt == S_WAIT) begin
            wait_cnt <= wait_cnt + 2'd1;
        end else begin
            wait_cnt <= 2'd0;
        end
    end

    // Read wins over Write when both are asserted.
    always_ff @(posedge clock) begin
        if (clear) begin
            addr_q <= '0;
            data_q <= 32'd0;
            op_rd  <= 1'b0;
            oor_q  <= 1'b0;
        end else if (state == S_IDLE && req) begin
            addr_q <= MARaddr[ADDR_W-1:0];
            data_q <= MDRdata;
            op_rd  <= Read;
            oor_q  <= oor_req;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            Mdatain <= 32'd0;
        end else if (state == S_ACCESS && op_rd) begin
            Mdatain <= oor_q ? 32'd0 : mem[addr_q];
        end
    end

    // RAM has no reset; a clear coinciding with the ACCESS edge still blocks the write.
    always_ff @(posedge clock) begin
        if (!clear && state == S_ACCESS && !op_rd && !oor_q) begin
            mem[addr_q] <= data_q;
        end
    end

    assign Busy      = (state != S_IDLE);
    assign Done      = (state == S_DONE);
    assign MDMuxread = (state == S_DONE) && op_rd;

`ifdef MEM_RANGE_CHECK_EN
    assign Err = (state == S_DONE) && oor_q;
`else
    assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed, table-driven bench for mem_ctrl at default WAIT_STATES plus two latency instances (0 and 3 wait states).
module tb_mem_ctrl;

    localparam int WS = 1;

    logic        clock;
    logic        clear;
    logic [31:0] MARaddr;
    logic [31:0] MDRdata;
    logic        Read;
    logic        Write;
    logic [31:0] Mdatain;
    logic        MDMuxread;
    logic        Done;
    logic        Busy;
    logic        Err;

    logic        lat_rd;
    logic [31:0] unused_md0;
    logic [31:0] unused_md3;
    logic        mux0, done0, busy0, err0;
    logic        mux3, done3, busy3, err3;

    int n_cmp = 0;
    int n_bad = 0;

    mem_ctrl #(.ADDR_W(9), .WAIT_STATES(WS)) dut (
        .clock(clock), .clear(clear), .MARaddr(MARaddr), .MDRdata(MDRdata),
        .Read(Read), .Write(Write), .Mdatain(Mdatain), .MDMuxread(MDMuxread),
        .Done(Done), .Busy(Busy), .Err(Err)
    );

    mem_ctrl #(.ADDR_W(9), .WAIT_STATES(0)) lat0 (
        .clock(clock), .clear(clear), .MARaddr(32'd0), .MDRdata(32'd0),
        .Read(lat_rd), .Write(1'b0), .Mdatain(unused_md0), .MDMuxread(mux0),
        .Done(done0), .Busy(busy0), .Err(err0)
    );

    mem_ctrl #(.ADDR_W(9), .WAIT_STATES(3)) lat3 (
        .clock(clock), .clear(clear), .MARaddr(32'd0), .MDRdata(32'd0),
        .Read(lat_rd), .Write(1'b0), .Mdatain(unused_md3), .MDMuxread(mux3),
        .Done(done3), .Busy(busy3), .Err(err3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_md;
        logic        exp_err;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issues one request from IDLE and checks every cycle up to and including DONE.
    task automatic run_op(input string nm, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_md, input logic exp_err);
        @(negedge clock);
        chk({nm, ".idle_busy"}, {31'd0, Busy}, 32'd0);
        Read    = rd;
        Write   = wr;
        MARaddr = addr;
        MDRdata = data;
        @(posedge clock);
        @(negedge clock);
        Read  = 1'b0;
        Write = 1'b0;
        for (int c = 1; c <= WS + 2; c++) begin
            if (c > 1) @(negedge clock);
            chk($sformatf("%s.busy_c%0d", nm, c), {31'd0, Busy}, 32'd1);
            chk($sformatf("%s.done_c%0d", nm, c), {31'd0, Done}, {31'd0, c == WS + 2});
            if (c == WS + 2) begin
                chk({nm, ".mux"},  {31'd0, MDMuxread}, {31'd0, rd});
                chk({nm, ".mdat"}, Mdatain, exp_md);
                chk({nm, ".err"},  {31'd0, Err}, {31'd0, exp_err});
            end else begin
                chk($sformatf("%s.err_c%0d", nm, c), {31'd0, Err}, 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] rng_md;
        logic        rng_err;

        vt[0] = '{1'b0, 1'b1, 32'h005, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vt[1] = '{1'b1, 1'b0, 32'h005, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b0, 1'b1, 32'h010, 32'h11111111, 32'hDEADBEEF, 1'b0};
        vt[3] = '{1'b1, 1'b1, 32'h010, 32'h22222222, 32'h11111111, 1'b0};
        vt[4] = '{1'b1, 1'b0, 32'h010, 32'h00000000, 32'h11111111, 1'b0};
        vt[5] = '{1'b0, 1'b1, 32'h1FF, 32'hA5A5A5A5, 32'h11111111, 1'b0};
        vt[6] = '{1'b0, 1'b1, 32'h000, 32'h0F0F0F0F, 32'h11111111, 1'b0};
        vt[7] = '{1'b1, 1'b0, 32'h1FF, 32'h00000000, 32'hA5A5A5A5, 1'b0};
        vt[8] = '{1'b1, 1'b0, 32'h000, 32'h00000000, 32'h0F0F0F0F, 1'b0};
        vt[9] = '{1'b0, 1'b1, 32'h020, 32'hCAFEF00D, 32'h0F0F0F0F, 1'b0};

        clear   = 1'b1;
        Read    = 1'b0;
        Write   = 1'b0;
        MARaddr = 32'd0;
        MDRdata = 32'd0;
        lat_rd  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        chk("rst.busy", {31'd0, Busy}, 32'd0);
        chk("rst.done", {31'd0, Done}, 32'd0);
        chk("rst.mux",  {31'd0, MDMuxread}, 32'd0);
        chk("rst.mdat", Mdatain, 32'd0);
        chk("rst.err",  {31'd0, Err}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].addr,
                   vt[i].data, vt[i].exp_md, vt[i].exp_err);
        end

        // Write pulse while busy must be dropped.
        @(negedge clock);
        Read    = 1'b1;
        MARaddr = 32'h005;
        @(posedge clock);
        @(negedge clock);
        Read    = 1'b0;
        Write   = 1'b1;
        MDRdata = 32'h0BADBAD0;
        @(negedge clock);
        Write = 1'b0;
        @(negedge clock);
        chk("busyign.done", {31'd0, Done}, 32'd1);
        chk("busyign.mdat", Mdatain, 32'hDEADBEEF);
        run_op("busyign.reread", 1'b1, 1'b0, 32'h005, 32'd0, 32'hDEADBEEF, 1'b0);

        // Clear during WAIT aborts the write.
        @(negedge clock);
        Write   = 1'b1;
        MARaddr = 32'h020;
        MDRdata = 32'h12345678;
        @(posedge clock);
        @(negedge clock);
        Write = 1'b0;
        chk("abort.in_wait", {31'd0, Busy}, 32'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("abort.busy", {31'd0, Busy}, 32'd0);
        chk("abort.done", {31'd0, Done}, 32'd0);
        chk("abort.mux",  {31'd0, MDMuxread}, 32'd0);
        chk("abort.mdat", Mdatain, 32'd0);
        chk("abort.err",  {31'd0, Err}, 32'd0);
        run_op("abort.read", 1'b1, 1'b0, 32'h020, 32'd0, 32'hCAFEF00D, 1'b0);

`ifdef MEM_RANGE_CHECK_EN
        rng_md  = 32'h00000000;
        rng_err = 1'b1;
`else
        rng_md  = 32'hDEADBEEF;
        rng_err = 1'b0;
`endif
        run_op("range", 1'b1, 1'b0, 32'h00000205, 32'd0, rng_md, rng_err);

        // Latency of the 0- and 3-wait-state instances.
        @(negedge clock);
        lat_rd = 1'b1;
        @(posedge clock);
        @(negedge clock);
        lat_rd = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clock);
            chk($sformatf("ws0.done_c%0d", c), {31'd0, done0}, {31'd0, c == 2});
            chk($sformatf("ws0.busy_c%0d", c), {31'd0, busy0}, {31'd0, c <= 2});
            chk($sformatf("ws3.done_c%0d", c), {31'd0, done3}, {31'd0, c == 5});
            chk($sformatf("ws3.busy_c%0d", c), {31'd0, busy3}, {31'd0, c <= 5});
            if (c == 2) begin
                chk("ws0.mux", {31'd0, mux0}, 32'd1);
                chk("ws0.err", {31'd0, err0}, 32'd0);
            end
            if (c == 5) begin
                chk("ws3.mux", {31'd0, mux3}, 32'd1);
                chk("ws3.err", {31'd0, err3}, 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have one clock `clock` and a synchronous, active-high reset `clear`.
REQ-002 Parameter `ADDR_W`, default 9, SHALL set the word-address width; the RAM depth SHALL be 2^ADDR_W 32-bit words.
REQ-003 Parameter `WAIT_STATES`, default 1, legal range 0..3, SHALL set the extra cycles inserted before each RAM access.
REQ-004 Port `clock`: input, 1 bit, rising-edge system clock.
REQ-005 Port `clear`: input, 1 bit, synchronous active-high reset.
REQ-006 Port `MARaddr`: input, 32 bits, word address taken from the MAR register output.
REQ-007 Port `MDRdata`: input, 32 bits, write data taken from the MDR register output.
REQ-008 Port `Read`: input, 1 bit, read request, sampled only in IDLE.
REQ-009 Port `Write`: input, 1 bit, write request, sampled only in IDLE.
REQ-010 Port `Mdatain`: output, 32 bits, read data driven to the MDR input mux.
REQ-011 Port `MDMuxread`: output, 1 bit, MDR mux select; high while `Mdatain` carries fresh read data.
REQ-012 Port `Done`: output, 1 bit, one-cycle pulse marking access completion.
REQ-013 Port `Busy`: output, 1 bit, high in every state other than IDLE.
REQ-014 Port `Err`: output, 1 bit, out-of-range access flag (see Configuration).

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT, ACCESS, DONE.
REQ-016 In IDLE, an edge with Read=1 or Write=1 SHALL latch `MARaddr[ADDR_W-1:0]`, `MDRdata` and the operation type.
  - Next state: WAIT if WAIT_STATES>0, otherwise ACCESS.
REQ-017 WAIT SHALL count exactly WAIT_STATES cycles, then go to ACCESS.
REQ-018 ACCESS SHALL last one cycle, then go to DONE.
  - Write: the latched data is written to the RAM at the latched address at the edge leaving ACCESS.
  - Read: the RAM word is registered into `Mdatain` at that same edge.
REQ-019 DONE SHALL last one cycle, then go to IDLE.
  - `Done`=1 during DONE.
  - `MDMuxread`=1 during DONE for reads only.
REQ-020 Latency: `Done` SHALL be high in exactly the (WAIT_STATES+2)th cycle after the request-sampling edge, i.e. 3 cycles at default.
REQ-021 Read=1 and Write=1 together in IDLE SHALL perform a read only; the write is dropped.
REQ-022 Read/Write asserted while Busy=1 SHALL be ignored and not queued.
  - A request held high through DONE is sampled again at the first IDLE edge.
REQ-023 `Mdatain` SHALL hold the last read value until the next read completes; writes SHALL NOT change it.
REQ-024 Write-then-read of the same address SHALL return the newly written data.
REQ-025 Back-to-back accesses SHALL have a minimum period of WAIT_STATES+3 cycles.

Reset
REQ-026 When `clear`=1 at an edge, the block SHALL force the following, regardless of state:
  - state=IDLE; Mdatain=0; MDMuxread=0; Done=0; Busy=0; Err=0; wait counter=0.
REQ-027 A clear arriving before the ACCESS edge SHALL abort a pending write, leaving the RAM unmodified.
REQ-028 RAM contents SHALL NOT be cleared by `clear`.

Configuration
REQ-029 Macro `MEM_RANGE_CHECK_EN` SHALL control range checking.
REQ-030 With `MEM_RANGE_CHECK_EN` defined, a request with `MARaddr[31:ADDR_W]`≠0 SHALL still traverse WAIT/ACCESS/DONE with normal latency, with these differences:
  - No RAM write occurs.
  - `Mdatain` is set to 0 for reads.
  - `Err`=1 during DONE only.
REQ-031 Without the macro, upper address bits SHALL be ignored (the address wraps modulo 2^ADDR_W), and `Err` SHALL be tied to 0.

Verification
REQ-032 Write then read: Write, MARaddr=0x05, MDRdata=0xDEADBEEF, then Read of 0x05 -> Mdatain=0xDEADBEEF, with MDMuxread=1 and Done=1 in cycle 3 after sampling.
REQ-033 Latency: WAIT_STATES=0 and WAIT_STATES=3 -> Done in cycle 2 and cycle 5 respectively; Busy high in every cycle from the sampling edge until Done.
REQ-034 Conflict and busy: Read=Write=1 at 0x10 (previously 0x11111111, MDRdata=0x22222222) -> read returns 0x11111111 and memory is unchanged; a Write pulse issued while Busy -> no effect.
REQ-035 Reset mid-op: Write 0x12345678 to 0x20 with clear pulsed during WAIT -> outputs all 0 next cycle; a later read of 0x20 returns the old value.
REQ-036 Range: MARaddr=0x00000205 with MEM_RANGE_CHECK_EN defined -> Err=1 and Mdatain=0; without the macro -> access hits word 0x005 and Err=0.
